// File: rtl/count_uart_tx.sv
// Captures a 16-bit count on request and sends it as a 3-byte 8N1 UART frame
// (HEADER, count[7:0], count[15:8]) on a single pad, LSB first.
module count_uart_tx #(
   parameter int          CLK_DIV = 434,
   parameter logic [7:0]  HEADER  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] count_in,
   input  logic        count_vld,
   output logic        tx,
   output logic        tx_oeb,
   output logic        busy,
   output logic        overrun
);

   localparam int             TW       = $clog2(CLK_DIV);
   localparam logic [TW-1:0]  BIT_LAST = TW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [1:0]    byte_idx, byte_idx_n;
   logic [7:0]    shift, shift_n;
   logic [15:0]   hold, hold_n;
   logic          tx_n, busy_n, overrun_n;
   logic          bit_end;

   assign bit_end = (timer == BIT_LAST);

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      shift_n    = shift;
      hold_n     = hold;
      unique case (state)
         IDLE: begin
            timer_n = '0;
            if (count_vld) begin
               hold_n     = count_in;
               shift_n    = HEADER;
               byte_idx_n = 2'd0;
               state_n    = START;
            end
         end
         START: begin
            timer_n = bit_end ? '0 : timer + 1'b1;
            if (bit_end) begin
               bit_idx_n = 3'd0;
               state_n   = DATA;
            end
         end
         DATA: begin
            timer_n = bit_end ? '0 : timer + 1'b1;
            if (bit_end) begin
               shift_n = shift >> 1;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            timer_n = bit_end ? '0 : timer + 1'b1;
            if (bit_end) begin
               if (byte_idx < 2'd2) begin
                  byte_idx_n = byte_idx + 2'd1;
                  shift_n    = (byte_idx == 2'd0) ? hold[7:0] : hold[15:8];
                  state_n    = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line and busy are registered from the next state so they line up with it.
   always_comb begin
      tx_n      = 1'b1;
      busy_n    = (state_n != IDLE);
      overrun_n = count_vld && (state != IDLE);
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shift    <= '0;
         hold     <= '0;
         tx       <= 1'b1;
         tx_oeb   <= 1'b1;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         shift    <= shift_n;
         hold     <= hold_n;
         tx       <= tx_n;
         tx_oeb   <= 1'b0;
         busy     <= busy_n;
         overrun  <= overrun_n;
      end
   end

endmodule

// File: tb/tb_count_uart_tx.sv
// Randomized bench for count_uart_tx: a frame-level model predicts busy, overrun,
// tx_oeb and the tx waveform every cycle, and a UART receiver checks decoded bytes.
module tb_count_uart_tx;

   localparam int D     = 4;
   localparam int FRAME = 30 * D;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] count_in = '0;
   logic        count_vld = 1'b0;
   logic        tx, tx_oeb, busy, overrun;

   int total = 0;
   int bad   = 0;

   count_uart_tx #(.CLK_DIV(D), .HEADER(8'hA5)) dut (
      .clk       (clk),
      .reset     (reset),
      .count_in  (count_in),
      .count_vld (count_vld),
      .tx        (tx),
      .tx_oeb    (tx_oeb),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference model: edge counter, start edge of the accepted frame,
   // its 30-bit line pattern and the expected byte queue.
   int          cyc     = 0;
   int          fstart  = -1;
   logic [29:0] fbits   = '1;
   logic        ovr_exp = 1'b0;
   logic        oeb_exp = 1'b1;
   logic [7:0]  exp_q[$];

   function automatic logic [29:0] frame_bits(input logic [15:0] v);
      logic [7:0]  b [3];
      logic [29:0] r;
      b[0] = 8'hA5; b[1] = v[7:0]; b[2] = v[15:8];
      for (int m = 0; m < 3; m++) begin
         r[m*10] = 1'b0;
         for (int i = 0; i < 8; i++) r[m*10 + 1 + i] = b[m][i];
         r[m*10 + 9] = 1'b1;
      end
      return r;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         fstart  = -1;
         ovr_exp = 1'b0;
         oeb_exp = 1'b1;
         exp_q.delete();
      end else begin
         cyc++;
         oeb_exp = 1'b0;
         ovr_exp = 1'b0;
         if (count_vld) begin
            if (fstart >= 0 && cyc <= fstart + FRAME) begin
               ovr_exp = 1'b1;
            end else begin
               fstart = cyc;
               fbits  = frame_bits(count_in);
               exp_q.push_back(8'hA5);
               exp_q.push_back(count_in[7:0]);
               exp_q.push_back(count_in[15:8]);
            end
         end
      end
   end

   // Per-cycle output checks plus a mid-bit sampling UART receiver.
   int         rx_k = 0;
   logic       rx_on = 1'b0;
   logic [9:0] rx_bits = '0;

   always @(negedge clk) begin
      int   off;
      logic busy_e, tx_e;
      off    = cyc - fstart;
      busy_e = (fstart >= 0) && (off >= 0) && (off < FRAME);
      tx_e   = busy_e ? fbits[off / D] : 1'b1;
      check("busy", 32'(busy), 32'(busy_e));
      check("tx", 32'(tx), 32'(tx_e));
      check("tx_oeb", 32'(tx_oeb), 32'(oeb_exp));
      check("overrun", 32'(overrun), 32'(ovr_exp));
      if (!reset) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (tx == 1'b0) begin
            rx_on = 1'b1;
            rx_k  = 0;
         end
      end else begin
         rx_k++;
         if (rx_k % D == D / 2) rx_bits[rx_k / D] = tx;
         if (rx_k == 9 * D + D / 2) begin
            rx_on = 1'b0;
            check("rx_start", 32'(rx_bits[0]), 32'd0);
            check("rx_stop", 32'(rx_bits[9]), 32'd1);
            check("rx_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rx_byte", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] v);
      count_in  = v;
      count_vld = 1'b1;
      step(1);
      count_vld = 1'b0;
   endtask

   initial begin
      // 1: reset then idle
      step(3);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_oeb", 32'(tx_oeb), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      reset = 1'b1;
      step(50);

      // 2: single frame 0x1234
      send(16'h1234);
      check("start_bit", 32'(tx), 32'd0);
      check("busy_rise", 32'(busy), 32'd1);
      step(FRAME + 10);

      // 3: request during a frame is dropped
      send(16'h1234);
      step(39);
      send(16'hFFFF);
      check("ovr_pulse", 32'(overrun), 32'd1);
      step(FRAME);

      // 4: vld held high, back-to-back frames
      count_in  = 16'h0001;
      count_vld = 1'b1;
      step(1);
      count_in  = 16'h8000;
      step(FRAME + 1);
      check("b2b_start", 32'(tx), 32'd0);
      step(60);
      count_vld = 1'b0;
      step(FRAME);

      // 5: async reset mid-frame, then a clean frame
      send(16'h5A5A);
      step(56);
      reset = 1'b0;
      #1;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_oeb", 32'(tx_oeb), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      step(3);
      reset = 1'b1;
      step(5);
      send(16'hBEEF);
      step(FRAME + 5);

      // 6: count_in churns after capture
      count_in  = 16'h00FF;
      count_vld = 1'b1;
      step(1);
      count_vld = 1'b0;
      repeat (FRAME + 5) begin
         count_in = 16'($urandom);
         step(1);
      end

      // random requests, gaps and hold lengths
      for (int n = 0; n < 12; n++) begin
         step($urandom_range(0, 150));
         count_in  = 16'($urandom);
         count_vld = 1'b1;
         step($urandom_range(1, 3));
         count_vld = 1'b0;
      end
      step(FRAME + 20);

      check("leftover_bytes", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
